// File: rtl/axi_master_bridge.sv
// axi_master_bridge: single-beat AXI4 master for CPU word requests; AXI_MASTER_ERR_EN adds cpu_err
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
module axi_master_bridge #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_wstrb,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_busy,
  output logic                    cpu_done,
  output logic [31:0]             cpu_rdata,
`ifdef AXI_MASTER_ERR_EN
  output logic                    cpu_err,
`endif
  output logic [`AXI_ID_BITS-1:0] ARID,
  output logic [31:0]             ARADDR,
  output logic [3:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [`AXI_ID_BITS-1:0] RID,
  input  logic [31:0]             RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic [`AXI_ID_BITS-1:0] AWID,
  output logic [31:0]             AWADDR,
  output logic [3:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [31:0]             WDATA,
  output logic [3:0]              WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [`AXI_ID_BITS-1:0] BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;
  state_t state, nxt;
  logic [31:0] addr, n_addr, n_wdata, n_rdata;
  logic [3:0] n_wstrb;
  logic n_arvalid, n_rready, n_awvalid, n_wvalid, n_wlast, n_bready, n_busy, n_done;
  logic aw_ok, w_ok, n_aw_ok, n_w_ok, err, n_err;
  logic aw_hs, w_hs, aw_fin, w_fin;
  logic unused;
  assign ARID = MASTER_ID;
  assign AWID = MASTER_ID;
  assign ARLEN = 4'd0;
  assign AWLEN = 4'd0;
  assign ARSIZE = 3'b010;
  assign AWSIZE = 3'b010;
  assign ARBURST = 2'b01;
  assign AWBURST = 2'b01;
  assign ARADDR = addr;
  assign AWADDR = addr;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign aw_fin = aw_ok || aw_hs;
  assign w_fin = w_ok || w_hs;
`ifdef AXI_MASTER_ERR_EN
  assign cpu_err = err;
  assign unused = ^{RID, BID, cpu_addr[1:0]};
`else
  assign unused = ^{RID, BID, RRESP, RLAST, BRESP, cpu_addr[1:0], err};
`endif
  always_comb begin
    nxt = state;
    n_addr = addr;
    n_wdata = WDATA;
    n_wstrb = WSTRB;
    n_rdata = cpu_rdata;
    n_arvalid = ARVALID;
    n_rready = RREADY;
    n_awvalid = AWVALID;
    n_wvalid = WVALID;
    n_wlast = WLAST;
    n_bready = BREADY;
    n_busy = cpu_busy;
    n_aw_ok = aw_ok;
    n_w_ok = w_ok;
    n_done = 1'b0;
    n_err = 1'b0;
    case (state)
      IDLE: if (cpu_req) begin
        n_addr = {cpu_addr[31:2], 2'b00};
        n_wdata = cpu_wdata;
        n_wstrb = cpu_wstrb;
        n_busy = 1'b1;
        nxt = cpu_we ? WR : RD_ADDR;
        n_arvalid = !cpu_we;
        n_awvalid = cpu_we;
        n_wvalid = cpu_we;
        n_wlast = cpu_we;
      end
      RD_ADDR: if (ARREADY) begin
        n_arvalid = 1'b0;
        n_rready = 1'b1;
        nxt = RD_DATA;
      end
      RD_DATA: if (RVALID) begin
        n_rdata = RDATA;
        n_rready = 1'b0;
        n_busy = 1'b0;
        n_done = 1'b1;
        n_err = (RRESP != 2'b00) || !RLAST;
        nxt = DONE;
      end
      WR: begin
        n_awvalid = AWVALID && !aw_hs;
        n_wvalid = WVALID && !w_hs;
        n_wlast = WVALID && !w_hs;
        n_aw_ok = aw_fin;
        n_w_ok = w_fin;
        if (aw_fin && w_fin) begin
          n_aw_ok = 1'b0;
          n_w_ok = 1'b0;
          n_bready = 1'b1;
          nxt = WR_RESP;
        end
      end
      WR_RESP: if (BVALID) begin
        n_bready = 1'b0;
        n_busy = 1'b0;
        n_done = 1'b1;
        n_err = BRESP != 2'b00;
        nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      WDATA <= '0;
      WSTRB <= '0;
      cpu_rdata <= '0;
      ARVALID <= 1'b0;
      RREADY <= 1'b0;
      AWVALID <= 1'b0;
      WVALID <= 1'b0;
      WLAST <= 1'b0;
      BREADY <= 1'b0;
      cpu_busy <= 1'b0;
      cpu_done <= 1'b0;
      aw_ok <= 1'b0;
      w_ok <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      addr <= n_addr;
      WDATA <= n_wdata;
      WSTRB <= n_wstrb;
      cpu_rdata <= n_rdata;
      ARVALID <= n_arvalid;
      RREADY <= n_rready;
      AWVALID <= n_awvalid;
      WVALID <= n_wvalid;
      WLAST <= n_wlast;
      BREADY <= n_bready;
      cpu_busy <= n_busy;
      cpu_done <= n_done;
      aw_ok <= n_aw_ok;
      w_ok <= n_w_ok;
      err <= n_err;
    end
  end
endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Converts single-word CPU-side memory requests into AXI4 master transactions on a 32-bit data / 32-bit address bus.
- This is the initiator end that drives the SRAM slave wrappers through the AXI interconnect.
- Every transaction is single-beat: LEN=0, SIZE=3'b010, BURST=INCR. One transaction is outstanding at a time.

Parameters:
- MASTER_ID, 4'd0, constant driven on ARID/AWID (`AXI_ID_BITS wide).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address; bits [1:0] ignored on AXI (forced to 0)
- cpu_wstrb  in  4  byte enables, active-high
- cpu_wdata  in  32  write data
- cpu_busy  out  1  high from acceptance until the cycle after completion
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data; valid while cpu_done=1 and held until the next read completes
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  4/32/4/3/2/1;  ARREADY  in  1
- RID  in  4;  RDATA  in  32;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  4/32/4/3/2/1;  AWREADY  in  1
- WDATA  out  32;  WSTRB  out  4;  WLAST  out  1;  WVALID  out  1;  WREADY  in  1
- BID  in  4;  BRESP  in  2;  BVALID  in  1;  BREADY  out  1

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, state=IDLE. All VALIDs, RREADY, BREADY, cpu_busy, cpu_done and WLAST are 0. cpu_rdata=0. Address/data registers are 0.
- Reset mid-operation: all outputs drop to reset values immediately. No transaction is resumed.
- Constant outputs: ARID=AWID=MASTER_ID, LEN=0, SIZE=2, BURST=2'b01.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE: on cpu_req=1, register addr (with [1:0]=0), wdata, wstrb and we; set cpu_busy=1.
  - Read: go to RD_ADDR with ARVALID=1.
  - Write: go to WR with AWVALID=1, WVALID=1, WLAST=1.
- RD_ADDR: ARVALID and ARADDR are held stable until ARREADY=1. In the handshake cycle, ARVALID<=0, RREADY<=1, go to RD_DATA.
- RD_DATA: on RVALID&&RREADY, capture RDATA into cpu_rdata, RREADY<=0, go to DONE. An RID mismatch is ignored (the interconnect strips/restores IDs).
- WR: AW and W handshake independently. Internal flags aw_ok and w_ok; each VALID deasserts in the cycle after its own handshake. Both handshakes may complete in the same cycle. When both are complete (flag set or handshake this cycle), BREADY<=1 and go to WR_RESP. WDATA/WSTRB are held stable while WVALID=1.
- WR_RESP: on BVALID&&BREADY, BREADY<=0, go to DONE.
- DONE: cpu_done=1 for exactly one cycle and cpu_busy=0. Next state is IDLE.
- cpu_done is registered. A new cpu_req is accepted no earlier than the cycle after DONE.
- cpu_req while busy is ignored; the CPU must hold the request until cpu_done.
- Minimum latency with READY=1 tied high:
  - Read: req accepted at cycle 0, ARVALID at 1, RREADY at 2, done at 3 if RVALID is already high.
  - Write: VALIDs at 1, BREADY at 2, done at 3.
- A VALID never deasserts before its handshake. No combinational path from READY to VALID.

Optional Feature:
- Macro: AXI_MASTER_ERR_EN. Adds output cpu_err (1 bit, reset 0).
- With the macro:
  - cpu_err pulses with cpu_done when the captured RRESP or BRESP is not OKAY (2'b00), or when a read beat arrives with RLAST=0.
  - cpu_rdata is still updated on error.
- Without the macro: the port is absent and responses are ignored.

Test Plan:
- Read with ARREADY/RVALID tied 1, RDATA=32'hDEADBEEF, addr 32'h0000_0103 -> ARADDR=32'h0000_0100, cpu_done at cycle 3, cpu_rdata=32'hDEADBEEF.
- Write with AWREADY delayed 3 cycles, WREADY=1 immediately -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR, BREADY rises only after AW completes, cpu_done after BVALID.
- Write with AWREADY and WREADY both 1 in the same cycle, wstrb=4'b0011 -> both VALIDs drop together, WSTRB=4'b0011, WLAST=1, done at cycle 3.
- Back-to-back: read then write with cpu_req held high -> second request is accepted only in the cycle after cpu_done. No overlapping VALIDs.
- rst asserted while in RD_DATA with RREADY=1 -> RREADY, cpu_busy and cpu_done become 0 asynchronously. After release, a fresh read completes normally.
- AXI_MASTER_ERR_EN defined, BRESP=2'b10 -> cpu_err=1 in the same cycle as cpu_done. A following read with RRESP=0 and RLAST=1 -> cpu_err=0.
